psum_col_port: RTL and testbench
================================

# psum_col_port

Per-column partial-sum port at the top of one PE column: the PE-side peer of the psum buffer for that column. It takes finished column psums from the PE array and, in MODE2, pops the matching stored psum from the buffer, accumulates it with saturation, and transmits the result back into the buffer's per-filter FIFO. It also returns the pop acknowledge the buffer uses to rotate its per-column filter pointer. One instance per column, seven in the array.

## Interface

Parameters:
- `PSUM_W`, default `` `PSUM_DATA_SIZE ``: psum data width, signed two's complement.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start_conv`  in  1  one-cycle start pulse; latches `mode_in` and clears all state.
- `mode_in`  in  OP_MODE  MODE1 or MODE2; sampled only on `start_conv`.
- `local_valid`  in  1  PE column presents a psum.
- `local_filter_idx`  in  2  filter index of the local psum.
- `local_psum`  in  PSUM_W  local psum value, signed.
- `local_ready`  out  1  local psum consumed this cycle when `local_valid` is also high.
- `psum_from_buf`  in  PSUM_PACKET  stored psum offered by the buffer (valid, filter_idx, psum).
- `pe_psum_ack`  out  1  pop strobe to the buffer for this column.
- `psum_to_buf`  out  PSUM_PACKET  packet written to the buffer.
- `psum_buffer_ack`  in  1  buffer FIFO for `psum_to_buf.filter_idx` is not full.
- `sat_cnt`  out  8  number of saturated accumulations since start; sticks at 255.
- `seq_err`  out  1  sticky filter-order violation flag.

## Operation

- **Mode register.** Reset value is MODE1. On `start_conv` it loads `mode_in`.
- **Clears.** `start_conv` or reset clears the output slot, `exp_idx`, `sat_cnt` and `seq_err`.
- **Output slot.** A single register holds `pend`, `idx[1:0]` and `data[PSUM_W-1:0]`.
  - `psum_to_buf.filter_idx = idx` and `psum_to_buf.psum = data`, driven at all times.
  - `psum_to_buf.valid = pend & psum_buffer_ack`.
  - The buffer writes on every cycle `valid` is high, so valid is never held across cycles for one packet.
  - A transfer occurs when `psum_to_buf.valid` is 1; `pend` clears that cycle unless refilled.
- **Slot free.** `slot_free = ~pend | (pend & psum_buffer_ack)`.
- **MODE1 (pass-through).**
  - `local_ready = slot_free`.
  - On consume: `idx <= local_filter_idx`, `data <= local_psum`, `pend <= 1`.
  - `pe_psum_ack` is 0.
- **MODE2 (accumulate).**
  - Counter `exp_idx` (2 bits) tracks the buffer's rotation: it starts at 0 and increments mod 4 on each pop.
  - `match = local_valid & psum_from_buf.valid & (local_filter_idx == exp_idx)`.
  - `local_ready = slot_free & psum_from_buf.valid & (local_filter_idx == exp_idx)`.
  - `pe_psum_ack = match & slot_free`, asserted in the same cycle as the local consume.
  - On consume: `data <= sat(local_psum + psum_from_buf.psum)` and `idx <= exp_idx`.
- **Saturation.** The sum is computed at PSUM_W+1 bits.
  - Positive overflow clamps to `2^(PSUM_W-1)-1`; negative overflow clamps to `-2^(PSUM_W-1)`.
  - Each clamp increments `sat_cnt`, which saturates at 255.
- **Sequence error.** In MODE2, if `local_valid & psum_from_buf.valid & (local_filter_idx != exp_idx)`:
  - set `seq_err`;
  - stall: no consume, no pop.
- **Never pop an empty buffer.** `pe_psum_ack` is never asserted while `psum_from_buf.valid` is 0.

## Timing

- **Reset values.** `psum_to_buf` is all-zero and invalid; `pe_psum_ack=0`; `sat_cnt=0`; `seq_err=0`. `local_ready` = 1 after reset (MODE1, slot empty).
- **Latency.** A local psum consumed in cycle N is presented at N+1. It transfers at N+1 if `psum_buffer_ack` is high, otherwise in the first later cycle where it is high.
- **Throughput.** One packet per cycle while the buffer is not full, because the slot refills in the same cycle it drains.
- **Buffer full.** `pend` holds, `psum_to_buf.valid=0`, `local_ready=0`, no pop.
- **`start_conv` with `pend=1`.** The pending packet is discarded and not transmitted. The new mode applies from the next cycle.
- **`start_conv` coincident with `local_valid`.** The local psum is not consumed that cycle (`local_ready` forced 0).
- **`exp_idx` wrap.** 3 goes to 0 on a pop.
- **Asynchronous reset mid-transfer.** All state clears immediately; no partial packet.

## Test plan

- **MODE1 stream.** After `start_conv` (MODE1), drive 4 locals, idx 0..3, psum 10,20,30,40, with `psum_buffer_ack=1`.
  - Required: valid packets on 4 consecutive cycles starting one cycle after the first consume, with matching idx and data.
  - `pe_psum_ack` stays 0 throughout.
- **MODE2 accumulate.** Buffer offers idx 0..3 with psum 100,-5,7,0; locals 1,2,3,4 in order.
  - Required: outputs 101,-3,10,4 on idx 0..3.
  - Four `pe_psum_ack` pulses, one per consume cycle; `exp_idx` ends at 0.
- **Saturation.** With PSUM_W=16 in MODE2, local 30000 plus buffer 10000 gives 32767; local -30000 plus buffer -10000 gives -32768.
  - Required: `sat_cnt=2`.
- **Backpressure.** With `pend=1`, hold `psum_buffer_ack=0` for 3 cycles.
  - Required: `psum_to_buf.valid=0` and `local_ready=0` for those 3 cycles.
  - Packet transfers exactly once when ack returns; no duplicate writes.
- **Sequence error.** In MODE2 with `exp_idx=0`, drive a local with idx 2 and buffer valid.
  - Required: `seq_err=1`, no pop, no consume.
  - `seq_err` stays 1 until the next `start_conv`.
- **Restart.** Pulse `start_conv` (MODE2) while `pend=1` and `sat_cnt=5`.
  - Required: next cycle `pend=0`, `sat_cnt=0`, `exp_idx=0`.
  - The old packet never appears on `psum_to_buf`.

Source files
------------

// File: rtl/psum_col_port.sv
// psum_col_port: PE-side partial-sum port for one column of the PE array.
// MODE1 forwards local psums to the buffer; MODE2 accumulates them with the buffer's stored psum.
`ifndef PSUM_DATA_SIZE
`define PSUM_DATA_SIZE 16
`endif

package psum_col_pkg;
    localparam int unsigned PSUM_DATA_W = `PSUM_DATA_SIZE;

    typedef enum logic {
        MODE1 = 1'b0,
        MODE2 = 1'b1
    } op_mode_t;

    typedef struct packed {
        logic                          valid;
        logic [1:0]                    filter_idx;
        logic signed [PSUM_DATA_W-1:0] psum;
    } psum_packet_t;
endpackage

module psum_col_port
    import psum_col_pkg::*;
#(
    parameter int unsigned PSUM_W = `PSUM_DATA_SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_conv,
    input  op_mode_t                 mode_in,
    input  logic                     local_valid,
    input  logic [1:0]               local_filter_idx,
    input  logic signed [PSUM_W-1:0] local_psum,
    output logic                     local_ready,
    input  psum_packet_t             psum_from_buf,
    output logic                     pe_psum_ack,
    output psum_packet_t             psum_to_buf,
    input  logic                     psum_buffer_ack,
    output logic [7:0]               sat_cnt,
    output logic                     seq_err
);
    localparam int unsigned SUM_W = PSUM_W + 1;
    localparam logic signed [PSUM_W-1:0] MAX_V = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] MIN_V = {1'b1, {(PSUM_W-1){1'b0}}};

    op_mode_t                 r_mode, w_mode_nxt;
    logic                     r_pend, w_pend_nxt;
    logic [1:0]               r_idx, w_idx_nxt;
    logic signed [PSUM_W-1:0] r_data, w_data_nxt;
    logic [1:0]               r_exp_idx, w_exp_nxt;
    logic [7:0]               r_sat_cnt, w_sat_nxt;
    logic                     r_seq_err, w_seq_nxt;

    logic                     w_m2;
    logic                     w_slot_free;
    logic                     w_idx_ok;
    logic                     w_xfer;
    logic                     w_ready;
    logic                     w_consume;
    logic                     w_seq_hit;
    logic signed [PSUM_W-1:0] w_buf_psum;
    logic signed [SUM_W-1:0]  w_sum;
    logic                     w_ovf;
    logic signed [PSUM_W-1:0] w_sat_val;
    logic                     w_unused;

    // The buffer's own filter index is implied by its rotation, tracked locally by r_exp_idx.
    assign w_unused   = ^psum_from_buf.filter_idx;

    assign w_m2       = (r_mode == MODE2);
    assign w_slot_free = ~r_pend | psum_buffer_ack;
    assign w_idx_ok   = (local_filter_idx == r_exp_idx);
    // A pending packet is discarded, never sent, when a new convolution starts.
    assign w_xfer     = r_pend & psum_buffer_ack & ~start_conv;
    assign w_ready    = ~start_conv & w_slot_free & (~w_m2 | (psum_from_buf.valid & w_idx_ok));
    assign w_consume  = w_ready & local_valid;
    assign w_seq_hit  = ~start_conv & w_m2 & local_valid & psum_from_buf.valid & ~w_idx_ok;

    // Sign-extended add, then clamp on overflow of the PSUM_W result.
    assign w_buf_psum = PSUM_W'(psum_from_buf.psum);
    assign w_sum      = SUM_W'(local_psum) + SUM_W'(w_buf_psum);
    assign w_ovf      = w_sum[SUM_W-1] ^ w_sum[SUM_W-2];
    assign w_sat_val  = w_ovf ? (w_sum[SUM_W-1] ? MIN_V : MAX_V) : w_sum[PSUM_W-1:0];

    assign local_ready            = w_ready;
    assign pe_psum_ack            = w_m2 & w_consume;
    assign psum_to_buf.valid      = w_xfer;
    assign psum_to_buf.filter_idx = r_idx;
    assign psum_to_buf.psum       = PSUM_DATA_W'(r_data);
    assign sat_cnt                = r_sat_cnt;
    assign seq_err                = r_seq_err;

    always_comb begin
        w_mode_nxt = r_mode;
        w_pend_nxt = r_pend;
        w_idx_nxt  = r_idx;
        w_data_nxt = r_data;
        w_exp_nxt  = r_exp_idx;
        w_sat_nxt  = r_sat_cnt;
        w_seq_nxt  = r_seq_err;
        if (start_conv) begin
            w_mode_nxt = mode_in;
            w_pend_nxt = 1'b0;
            w_idx_nxt  = 2'd0;
            w_data_nxt = '0;
            w_exp_nxt  = 2'd0;
            w_sat_nxt  = 8'd0;
            w_seq_nxt  = 1'b0;
        end else begin
            if (w_consume) begin
                w_pend_nxt = 1'b1;
                if (w_m2) begin
                    w_idx_nxt  = r_exp_idx;
                    w_data_nxt = w_sat_val;
                    w_exp_nxt  = r_exp_idx + 2'd1;
                    if (w_ovf && (r_sat_cnt != 8'hFF)) begin
                        w_sat_nxt = r_sat_cnt + 8'd1;
                    end
                end else begin
                    w_idx_nxt  = local_filter_idx;
                    w_data_nxt = local_psum;
                end
            end else if (w_xfer) begin
                w_pend_nxt = 1'b0;
            end
            if (w_seq_hit) begin
                w_seq_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE1;
            r_pend    <= 1'b0;
            r_idx     <= 2'd0;
            r_data    <= '0;
            r_exp_idx <= 2'd0;
            r_sat_cnt <= 8'd0;
            r_seq_err <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_pend    <= w_pend_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_exp_idx <= w_exp_nxt;
            r_sat_cnt <= w_sat_nxt;
            r_seq_err <= w_seq_nxt;
        end
    end
endmodule

// File: tb/tb_psum_col_port.sv
// Testbench for psum_col_port: vector table, directed corner sequences and a randomized run
// checked every cycle against an arithmetic reference model.
module tb_psum_col_port;
    import psum_col_pkg::*;

    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_conv;
    op_mode_t           mode_in;
    logic               local_valid;
    logic [1:0]         local_filter_idx;
    logic signed [15:0] local_psum;
    logic               local_ready;
    psum_packet_t       psum_from_buf;
    logic               pe_psum_ack;
    psum_packet_t       psum_to_buf;
    logic               psum_buffer_ack;
    logic [7:0]         sat_cnt;
    logic               seq_err;

    psum_col_port #(.PSUM_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_conv       (start_conv),
        .mode_in          (mode_in),
        .local_valid      (local_valid),
        .local_filter_idx (local_filter_idx),
        .local_psum       (local_psum),
        .local_ready      (local_ready),
        .psum_from_buf    (psum_from_buf),
        .pe_psum_ack      (pe_psum_ack),
        .psum_to_buf      (psum_to_buf),
        .psum_buffer_ack  (psum_buffer_ack),
        .sat_cnt          (sat_cnt),
        .seq_err          (seq_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_pop   = 0;

    // Reference model state: mode, output slot, expected filter, counters.
    int m_mode, m_pend, m_idx, m_data, m_exp, m_sat, m_seq;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_idx = 0; m_data = 0;
        m_exp = 0; m_sat = 0; m_seq = 0;
    endtask

    task automatic drive(input bit lv, input int lidx, input int lp, input bit bv, input int bp, input bit ack);
        local_valid            = lv;
        local_filter_idx       = 2'(lidx);
        local_psum             = 16'(lp);
        psum_from_buf.valid    = bv;
        psum_from_buf.filter_idx = 2'(lidx);
        psum_from_buf.psum     = 16'(bp);
        psum_buffer_ack        = ack;
    endtask

    // One clock: compare combinational and registered outputs mid-cycle, then advance the model.
    task automatic step(input string tag);
        int e_ready, e_ack, e_valid, sum, lp, bp;
        bit free;
        @(negedge clk);
        free    = (m_pend == 0) || psum_buffer_ack;
        e_ready = (!start_conv && free &&
                   (m_mode == 0 || (psum_from_buf.valid && int'(local_filter_idx) == m_exp))) ? 1 : 0;
        e_ack   = (m_mode == 1 && e_ready == 1 && local_valid) ? 1 : 0;
        e_valid = (m_pend == 1 && psum_buffer_ack && !start_conv) ? 1 : 0;
        chk({tag, " local_ready"}, int'(local_ready), e_ready);
        chk({tag, " pe_psum_ack"}, int'(pe_psum_ack), e_ack);
        chk({tag, " out_valid"}, int'(psum_to_buf.valid), e_valid);
        chk({tag, " out_idx"}, int'(psum_to_buf.filter_idx), m_idx);
        chk({tag, " out_data"}, int'($signed(psum_to_buf.psum)), m_data);
        chk({tag, " sat_cnt"}, int'(sat_cnt), m_sat);
        chk({tag, " seq_err"}, int'(seq_err), m_seq);
        if (psum_to_buf.valid) n_xfer++;
        if (pe_psum_ack) n_pop++;
        lp = int'(local_psum);
        bp = int'($signed(psum_from_buf.psum));
        if (start_conv) begin
            model_reset();
            m_mode = (mode_in == MODE2) ? 1 : 0;
        end else begin
            if (m_mode == 1 && local_valid && psum_from_buf.valid && int'(local_filter_idx) != m_exp)
                m_seq = 1;
            if (e_ready == 1 && local_valid) begin
                m_pend = 1;
                if (m_mode == 1) begin
                    sum = lp + bp;
                    if (sum > MAXV || sum < MINV) begin
                        sum   = (sum > MAXV) ? MAXV : MINV;
                        m_sat = (m_sat < 255) ? m_sat + 1 : 255;
                    end
                    m_data = sum;
                    m_idx  = m_exp;
                    m_exp  = (m_exp + 1) % 4;
                end else begin
                    m_data = lp;
                    m_idx  = int'(local_filter_idx);
                end
            end else if (e_valid == 1) begin
                m_pend = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input op_mode_t m);
        drive(0, 0, 0, 0, 0, 1);
        start_conv = 1'b1;
        mode_in    = m;
        step("start");
        start_conv = 1'b0;
    endtask

    typedef struct {
        bit m2;
        int lidx;
        int lpsum;
        int bpsum;
        int eidx;
        int edata;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int x0, p0;
        tbl[0] = '{0, 0, 10, 0, 0, 10};
        tbl[1] = '{0, 1, 20, 0, 1, 20};
        tbl[2] = '{0, 2, 30, 0, 2, 30};
        tbl[3] = '{0, 3, 40, 0, 3, 40};
        tbl[4] = '{1, 0, 1, 100, 0, 101};
        tbl[5] = '{1, 1, 2, -5, 1, -3};
        tbl[6] = '{1, 2, 3, 7, 2, 10};
        tbl[7] = '{1, 3, 4, 0, 3, 4};
        tbl[8] = '{1, 0, 30000, 10000, 0, 32767};
        tbl[9] = '{1, 1, -30000, -10000, 1, -32768};

        rst_n = 1'b0; start_conv = 1'b0; mode_in = MODE1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset out_pkt", int'(psum_to_buf), 0);
        chk("reset pe_psum_ack", int'(pe_psum_ack), 0);
        chk("reset sat_cnt", int'(sat_cnt), 0);
        chk("reset seq_err", int'(seq_err), 0);
        chk("reset local_ready", int'(local_ready), 1);
        rst_n = 1'b1;
        step("idle");

        // Vector table: MODE1 stream, MODE2 accumulate, saturation.
        for (int i = 0; i < 10; i++) begin
            if (i == 0) do_start(MODE1);
            if (i == 4 || i == 8) begin do_start(MODE2); n_pop = 0; end
            drive(1, tbl[i].lidx, tbl[i].lpsum, tbl[i].m2, tbl[i].bpsum, 1);
            step("vec");
            chk($sformatf("vec%0d valid", i), int'(psum_to_buf.valid), 1);
            chk($sformatf("vec%0d idx", i), int'(psum_to_buf.filter_idx), tbl[i].eidx);
            chk($sformatf("vec%0d data", i), int'($signed(psum_to_buf.psum)), tbl[i].edata);
            if (i == 3 || i == 7 || i == 9) begin
                drive(0, 0, 0, 1, 0, 1);
                step("drain");
            end
            if (i == 3) chk("mode1 no pops", n_pop, 0);
            if (i == 7) begin
                chk("mode2 pop count", n_pop, 4);
                chk("mode2 exp_idx wrapped", int'(local_ready), 1);
            end
            if (i == 9) chk("sat_cnt two clamps", int'(sat_cnt), 2);
            if (i == 0) n_pop = 0;
        end

        // Backpressure: packet held three cycles, transferred exactly once.
        do_start(MODE1);
        drive(1, 1, 77, 0, 0, 1);
        step("bp load");
        drive(1, 2, 88, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step("bp hold");
            chk("bp hold valid", int'(psum_to_buf.valid), 0);
            chk("bp hold ready", int'(local_ready), 0);
        end
        x0 = n_xfer;
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step("bp release");
        chk("bp single transfer", n_xfer - x0, 1);

        // Sequence error: wrong filter index stalls and sets a sticky flag.
        do_start(MODE2);
        p0 = n_pop;
        drive(1, 2, 5, 1, 5, 1);
        step("seq bad");
        chk("seq_err set", int'(seq_err), 1);
        chk("seq no pop", n_pop - p0, 0);
        drive(0, 0, 0, 0, 0, 1);
        step("seq idle");
        step("seq idle");
        chk("seq_err sticky", int'(seq_err), 1);
        drive(1, 0, 5, 1, 6, 1);
        step("seq recover");
        chk("seq recover data", int'($signed(psum_to_buf.psum)), 11);
        do_start(MODE2);
        chk("seq_err cleared", int'(seq_err), 0);

        // Restart with a pending packet and sat_cnt=5.
        for (int k = 0; k < 5; k++) begin
            drive(1, k % 4, 30000, 1, 10000, 1);
            step("rs sat");
        end
        drive(0, 0, 0, 0, 0, 0);
        step("rs hold");
        chk("rs sat_cnt 5", int'(sat_cnt), 5);
        x0 = n_xfer;
        drive(0, 0, 0, 0, 0, 1);
        start_conv = 1'b1; mode_in = MODE2;
        step("rs start");
        start_conv = 1'b0;
        chk("rs slot empty", int'(psum_to_buf.valid), 0);
        chk("rs sat_cnt clear", int'(sat_cnt), 0);
        chk("rs old packet dropped", n_xfer - x0, 0);
        drive(1, 0, 2, 1, 1, 1);
        step("rs exp0");
        chk("rs exp_idx zero data", int'($signed(psum_to_buf.psum)), 3);

        // Asynchronous reset while a packet is pending.
        do_start(MODE1);
        drive(1, 3, 55, 0, 0, 0);
        step("ar load");
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset out_pkt", int'(psum_to_buf), 0);
        chk("areset ready", int'(local_ready), 1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("ar after");

        // Randomized run against the model.
        for (int c = 0; c < 800; c++) begin
            int lidx, lp, bp;
            start_conv = ($urandom_range(0, 59) == 0);
            mode_in    = ($urandom_range(0, 1) == 0) ? MODE1 : MODE2;
            lidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : m_exp;
            lp   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                               : int'($urandom_range(0, 200)) - 100;
            bp   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                               : int'($urandom_range(0, 200)) - 100;
            drive($urandom_range(0, 3) != 0, lidx, lp, $urandom_range(0, 4) != 0, bp,
                  $urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
